// File: rtl/alu_exec.sv
// alu_exec: registered ALU execute stage behind ALUcontrol.
// Two-entry skid buffer, registered in_ready, illegal-op counter.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [7:0]       err_count
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic [WIDTH-1:0] n_res;
  logic             n_ov;
  logic             n_ill;
  logic             n_zero;

  logic [WIDTH-1:0] s_res;
  logic             s_zero;
  logic             s_ov;
  logic             s_ill;
  logic             s_valid;
  logic             s_nxt;

  logic             acc;
  logic             pop;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt   = $signed(op_a) < $signed(op_b);
  assign acc  = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Decode the control code into the entry captured at acceptance
  always_comb begin
    n_res = '0;
    n_ov  = 1'b0;
    n_ill = 1'b0;
    case (alu_ctl)
      4'd0:  n_res = op_a & op_b;
      4'd1:  n_res = op_a | op_b;
      4'd2: begin
        n_res = sum;
        n_ov  = (op_a[MSB] == op_b[MSB]) &&
                (sum[MSB] != op_a[MSB]);
      end
      4'd6: begin
        n_res = diff;
        n_ov  = (op_a[MSB] != op_b[MSB]) &&
                (diff[MSB] != op_a[MSB]);
      end
      4'd7:  n_res = {{(WIDTH-1){1'b0}}, lt};
      4'd12: n_res = ~(op_a | op_b);
      default: n_ill = 1'b1;
    endcase
    n_zero = (n_res == '0);
  end

  // Skid occupancy after this edge; in_ready is its registered inverse
  always_comb begin
    s_nxt = s_valid;
    if (pop && s_valid)
      s_nxt = 1'b0;
    else if (acc && out_valid && !pop)
      s_nxt = 1'b1;
  end

  // Main/skid entry movement
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      s_valid   <= 1'b0;
      s_res     <= '0;
      s_zero    <= 1'b0;
      s_ov      <= 1'b0;
      s_ill     <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (pop && s_valid) begin
        result   <= s_res;
        zero     <= s_zero;
        overflow <= s_ov;
        illegal  <= s_ill;
        s_valid  <= 1'b0;
      end else if (acc && (!out_valid || pop)) begin
        result    <= n_res;
        zero      <= n_zero;
        overflow  <= n_ov;
        illegal   <= n_ill;
        out_valid <= 1'b1;
      end else if (acc) begin
        s_res   <= n_res;
        s_zero  <= n_zero;
        s_ov    <= n_ov;
        s_ill   <= n_ill;
        s_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      in_ready <= !s_nxt;
    end
  end

  // Saturating count of accepted illegal operations
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= 8'd0;
    else if (acc && n_ill && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec.
// Model entries queued on accept, compared on pop.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic [7:0]  err_count;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero),
    .overflow(overflow), .illegal(illegal),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errm = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (c)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2: begin
        s = sa + sb;
        e.res = s[31:0];
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = sa - sb;
        e.res = s[31:0];
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e.res = ~(a | b);
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    in_valid = v;
    alu_ctl = c;
    op_a = a;
    op_b = b;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("err_count", err_count, errm);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("overflow", overflow, e.ov);
        chk("illegal", illegal, e.ill);
      end
    end
    if (in_valid && in_ready) begin
      e = model(c, a, b);
      q.push_back(e);
      if (e.ill && errm < 255) errm++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    alu_ctl = 4'd2;
    op_a = 32'd1;
    op_b = 32'd1;
    out_ready = 1'b1;
    #1;
    q.delete();
    errm = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'($urandom_range(0, 3));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    alu_ctl = 4'd0;
    op_a = '0;
    op_b = '0;
    out_ready = 1'b0;
    do_reset();
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk_reset_vals("rst");

    // basic ADD
    cycle(1, 4'd2, 32'd5, 32'd7, 1);
    cycle(0, 0, 0, 0, 1);
    chk("add_res", result, 32'd12);
    chk("add_flags", {zero, overflow, illegal}, 3'b000);

    cycle(1, 4'd2, 32'h7FFF_FFFF, 32'd1, 1);
    cycle(0, 0, 0, 0, 1);
    chk("ovf_res", result, 32'h8000_0000);
    chk("ovf_flag", overflow, 1);

    cycle(1, 4'd6, 32'd3, 32'd3, 1);
    cycle(0, 0, 0, 0, 1);
    chk("sub_zero", {result, zero}, {32'd0, 1'b1});

    cycle(1, 4'd7, 32'h8000_0000, 32'd1, 1);
    cycle(0, 0, 0, 0, 1);
    chk("slt_res", result, 32'd1);

    cycle(1, 4'd12, 32'd0, 32'd0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("nor_res", result, 32'hFFFF_FFFF);

    // backpressure: only two accepted
    cycle(1, 4'd0, 32'hF0F0, 32'hFF00, 0);
    cycle(1, 4'd1, 32'hF0F0, 32'h0F0F, 0);
    cycle(1, 4'd2, 32'd10, 32'd20, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_depth", q.size(), 2);
    cycle(1, 4'd2, 32'd10, 32'd20, 1);
    chk("bp_first", result, 32'h0000_F000);
    cycle(1, 4'd2, 32'd10, 32'd20, 1);
    chk("bp_second", result, 32'h0000_FFFF);
    cycle(0, 0, 0, 0, 1);
    chk("bp_third", {out_valid, result}, {1'b1, 32'd30});
    cycle(0, 0, 0, 0, 1);

    // illegal codes
    do_reset();
    cycle(1, 4'd15, 32'd9, 32'd9, 1);
    cycle(1, 4'd3, 32'd9, 32'd9, 1);
    chk("ill_flags", {result, illegal, zero}, {32'd0, 1'b1, 1'b1});
    cycle(0, 0, 0, 0, 1);
    chk("ill_count2", err_count, 8'd2);
    for (int i = 0; i < 300; i++)
      cycle(1, 4'd15, $urandom, $urandom, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("ill_sat", err_count, 8'd255);

    // reset mid-operation with both entries full
    cycle(1, 4'd2, 32'd1, 32'd2, 0);
    cycle(1, 4'd15, 32'd3, 32'd4, 0);
    cycle(0, 0, 0, 0, 0);
    chk("mid_full", in_ready, 0);
    do_reset();
    cycle(0, 0, 0, 0, 1);
    chk_reset_vals("mid");
    cycle(0, 0, 0, 0, 1);
    chk("mid_no_stale", out_valid, 0);

    // randomized handshake
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), pick_op(),
            pick(), pick(), 1'($urandom_range(0, 1)));

    // drain with a bounded wait
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle(0, 0, 0, 0, 1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    cycle(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
